// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: register-file geometry,
// data width, enable levels and the output-register state encoding.
package operand_fetch_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned XLEN    = 32;

  localparam logic [XLEN-1:0] ZeroWord = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy scoreboard for the integer register file.
//   clk, rst     : clock, asynchronous active-low reset
//   rdy          : global ready; low freezes the busy bits
//   flush        : clears every busy bit (when rdy)
//   wb_we/wb_addr: writeback, clears the busy bit of wb_addr
//   set_en/addr  : issue of an instruction writing set_addr, sets its busy bit
//   chk_*        : instruction under test for RAW/WAW hazards
//   hazard       : a used source or the destination is effectively busy
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      flush,
  input  logic      wb_we,
  input  reg_addr_t wb_addr,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      chk_valid,
  input  logic      chk_use_rs1,
  input  reg_addr_t chk_rs1,
  input  logic      chk_use_rs2,
  input  reg_addr_t chk_rs2,
  input  logic      chk_rd_we,
  input  reg_addr_t chk_rd,
  output logic      hazard
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [REG_NUM-1:0] eb;

  // A writeback landing this cycle already satisfies the dependency, since
  // the register file bypasses it onto the read ports.
  always_comb begin
    eb = '0;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      eb[r] = busy_q[r] & ~(wb_we & rdy & (wb_addr == reg_addr_t'(r)));
    end
  end

  assign hazard = chk_valid & ((chk_use_rs1 & eb[chk_rs1]) |
                               (chk_use_rs2 & eb[chk_rs2]) |
                               ((chk_rd_we == WriteEnable) & eb[chk_rd]));

  // Set is applied after clear so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rdy) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (wb_we)  busy_d[wb_addr]  = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage between decode and execute.
//   clk, rst         : clock, asynchronous active-low reset
//   rdy              : global ready; low freezes all state
//   flush            : squash held output and clear the scoreboard
//   in_*             : decoded instruction (valid/ready handshake)
//   re*/raddr*       : register-file read ports (combinational from inputs)
//   rdata*           : register-file read data (with same-cycle write bypass)
//   wb_we/wb_addr    : writeback bus, clears busy bits
//   out_*            : one-entry registered output (valid/ready handshake)
//   stall_cnt        : saturating count of hazard-stall cycles
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_use_rs1,
  input  logic          in_use_rs2,
  input  reg_addr_t     in_rs1,
  input  reg_addr_t     in_rs2,
  input  logic          in_rd_we,
  input  reg_addr_t     in_rd,
  input  logic [PW-1:0] in_payload,
  output logic          re1,
  output logic          re2,
  output reg_addr_t     raddr1,
  output reg_addr_t     raddr2,
  input  word_t         rdata1,
  input  word_t         rdata2,
  input  logic          wb_we,
  input  reg_addr_t     wb_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output word_t         out_op1,
  output word_t         out_op2,
  output logic          out_rd_we,
  output reg_addr_t     out_rd,
  output logic [PW-1:0] out_payload,
  output logic [31:0]   stall_cnt
);

  out_state_e    state_q, state_d;
  word_t         op1_q, op1_d;
  word_t         op2_q, op2_d;
  logic          rd_we_q, rd_we_d;
  reg_addr_t     rd_q, rd_d;
  logic [PW-1:0] payload_q, payload_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic slot_free;
  logic issue;
  logic stall;
  logic set_en;

  function automatic word_t src_word(input logic used, input reg_addr_t addr,
                                     input word_t data);
    return (used && addr != '0) ? data : ZeroWord;
  endfunction

  assign re1    = (in_valid && in_use_rs1) ? ReadEnable : ReadDisable;
  assign re2    = (in_valid && in_use_rs2) ? ReadEnable : ReadDisable;
  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  assign slot_free = (state_q == OUT_EMPTY) | out_ready;
  assign in_ready  = rdy & ~flush & slot_free & ~hazard;
  assign issue     = in_valid & in_ready;
  assign stall     = rdy & in_valid & ~flush & hazard;
  assign set_en    = issue & (in_rd_we == WriteEnable) & (in_rd != '0);

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .set_en     (set_en),
    .set_addr   (in_rd),
    .chk_valid  (in_valid),
    .chk_use_rs1(in_use_rs1),
    .chk_rs1    (in_rs1),
    .chk_use_rs2(in_use_rs2),
    .chk_rs2    (in_rs2),
    .chk_rd_we  (in_rd_we),
    .chk_rd     (in_rd),
    .hazard     (hazard)
  );

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_we_d     = rd_we_q;
    rd_d        = rd_q;
    payload_d   = payload_q;
    stall_cnt_d = stall_cnt_q;

    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;

    if (rdy) begin
      if (flush) begin
        state_d = OUT_EMPTY;
      end else if (issue) begin
        state_d   = OUT_FULL;
        op1_d     = src_word(in_use_rs1, in_rs1, rdata1);
        op2_d     = src_word(in_use_rs2, in_rs2, rdata2);
        rd_we_d   = in_rd_we;
        rd_d      = in_rd;
        payload_d = in_payload;
      end else if (out_ready) begin
        state_d = OUT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= OUT_EMPTY;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_we_q     <= 1'b0;
      rd_q        <= '0;
      payload_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_we_q     <= rd_we_d;
      rd_q        <= rd_d;
      payload_q   <= payload_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = (state_q == OUT_FULL);
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rd_we   = rd_we_q;
  assign out_rd      = rd_q;
  assign out_payload = payload_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
`timescale 1ns/1ps
module tb_operand_fetch;

  logic clk;
  logic rst, rdy, flush;
  logic in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_we;
  logic [4:0] in_rs1, in_rs2, in_rd, raddr1, raddr2, wb_addr, out_rd;
  logic [31:0] in_payload, rdata1, rdata2, out_op1, out_op2, out_payload, stall_cnt, wb_data;
  logic re1, re2, wb_we, out_valid, out_ready, out_rd_we;

  logic [31:0] regs [32];
  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_op1, m_op2, m_payload, m_cnt;
  bit          m_rd_we;
  logic [4:0]  m_rd;

  operand_fetch #(.PW(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_we(in_rd_we), .in_rd(in_rd),
    .in_payload(in_payload),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd_we(out_rd_we), .out_rd(out_rd),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment: x0 is zero, writes bypass to same-cycle reads.
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    if (rdy && wb_we && wb_addr == raddr1 && raddr1 != 5'd0) rdata1 = wb_data;
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
    if (rdy && wb_we && wb_addr == raddr2 && raddr2 != 5'd0) rdata2 = wb_data;
  end

  function automatic bit m_eb(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(rdy && wb_we && wb_addr == r);
  endfunction

  function automatic bit m_hazard();
    return in_valid && ((in_use_rs1 && m_eb(in_rs1)) || (in_use_rs2 && m_eb(in_rs2)) ||
                        (in_rd_we && m_eb(in_rd)));
  endfunction

  function automatic bit m_in_ready();
    return rdy && !flush && (!m_valid || out_ready) && !m_hazard();
  endfunction

  function automatic logic [31:0] src_val(input bit used, input logic [4:0] r);
    if (!used || r == 5'd0) return 32'd0;
    if (rdy && wb_we && wb_addr == r) return wb_data;
    return regs[r];
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_payload = '0; m_cnt = '0;
    m_rd_we = 1'b0; m_rd = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic step();
    bit iss, do_wr, nv, nwe;
    bit nb [32];
    logic [31:0] n1, n2, np, nc, wdat;
    logic [4:0] nrd, waddr;
    iss = in_valid && m_in_ready();
    nb = m_busy; nv = m_valid; n1 = m_op1; n2 = m_op2; np = m_payload;
    nc = m_cnt; nwe = m_rd_we; nrd = m_rd;
    do_wr = rdy && wb_we && wb_addr != 5'd0; waddr = wb_addr; wdat = wb_data;
    if (rdy) begin
      if (in_valid && !flush && m_hazard() && m_cnt != 32'hFFFF_FFFF) nc = m_cnt + 1;
      if (flush) begin
        foreach (nb[i]) nb[i] = 1'b0;
        nv = 1'b0;
      end else begin
        if (wb_we) nb[wb_addr] = 1'b0;
        if (iss) begin
          if (in_rd_we && in_rd != 5'd0) nb[in_rd] = 1'b1;
          nv = 1'b1;
          n1 = src_val(in_use_rs1, in_rs1);
          n2 = src_val(in_use_rs2, in_rs2);
          np = in_payload; nwe = in_rd_we; nrd = in_rd;
        end else if (out_ready) begin
          nv = 1'b0;
        end
      end
    end
    @(posedge clk);
    m_busy = nb; m_valid = nv; m_op1 = n1; m_op2 = n2; m_payload = np;
    m_cnt = nc; m_rd_we = nwe; m_rd = nrd;
    #1;
    if (do_wr) regs[waddr] = wdat;
  endtask

  task automatic drive_idle();
    rdy = 1; flush = 0; in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_rd_we = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_payload = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic drive_instr(input bit u1, input logic [4:0] r1, input bit u2,
                             input logic [4:0] r2, input bit we, input logic [4:0] rd);
    in_valid = 1; in_use_rs1 = u1; in_rs1 = r1; in_use_rs2 = u2; in_rs2 = r2;
    in_rd_we = we; in_rd = rd; in_payload = $urandom;
  endtask

  task automatic clean();
    drive_idle();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
    checks++; if ({out_op1, out_op2, out_payload} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h_%h_%h exp=0", out_op1, out_op2, out_payload); end
    rst = 1;
    drive_instr(0, 0, 0, 0, 1, 5);
    step();
    drive_instr(1, 5, 0, 0, 0, 0);
    out_ready = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_pre_stall got=%b exp=0", in_ready); end
    step();
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL reset_pre_cnt got=%h exp=1", stall_cnt); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid); end
    // asynchronous reset mid-cycle
    rst = 0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL async_cnt got=%h exp=0", stall_cnt); end
    checks++; if ({out_op1, out_op2, out_payload, out_rd, out_rd_we} !== 102'd0) begin failures++; $display("FAIL async_fields got=%h_%h_%h_%h_%b exp=0", out_op1, out_op2, out_payload, out_rd, out_rd_we); end
    rst = 1;
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_busy_clear got=%b exp=1", in_ready); end
  endtask

  task automatic test_independent();
    clean();
    drive_instr(1, 1, 1, 2, 1, 3);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_rdy0 got=%b exp=1", in_ready); end
    step();
    drive_instr(1, 4, 1, 5, 1, 6);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_rdy1 got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL indep_valid0 got=%b exp=1", out_valid); end
    checks++; if (out_op1 !== regs[1] || out_op2 !== regs[2]) begin failures++; $display("FAIL indep_ops0 got=%h,%h exp=%h,%h", out_op1, out_op2, regs[1], regs[2]); end
    step();
    checks++; if (out_op1 !== regs[4] || out_op2 !== regs[5] || out_rd !== 5'd6) begin failures++; $display("FAIL indep_ops1 got=%h,%h,%0d exp=%h,%h,6", out_op1, out_op2, out_rd, regs[4], regs[5]); end
    drive_idle();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL indep_drain got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL indep_cnt got=%h exp=0", stall_cnt); end
  endtask

  task automatic test_raw();
    logic [31:0] base;
    clean();
    base = stall_cnt;
    drive_instr(0, 0, 0, 0, 1, 7);
    step();
    drive_instr(1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall%0d got=%b exp=0", i, in_ready); end
      step();
    end
    checks++; if (stall_cnt !== base + 32'd3) begin failures++; $display("FAIL raw_cnt got=%h exp=%h", stall_cnt, base + 32'd3); end
    wb_we = 1; wb_addr = 7; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_issue got=%b exp=1", in_ready); end
    step();
    checks++; if (out_op1 !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_bypass got=%h exp=deadbeef", out_op1); end
    drive_idle();
    step();
  endtask

  task automatic test_collision();
    clean();
    drive_instr(0, 0, 0, 0, 1, 9);
    step();
    drive_instr(0, 0, 0, 0, 1, 9);
    wb_we = 1; wb_addr = 9; wb_data = $urandom;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL coll_issue got=%b exp=1", in_ready); end
    step();
    wb_we = 0;
    drive_instr(1, 9, 0, 0, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL coll_set_wins got=%b exp=0", in_ready); end
    step();
    drive_idle();
    wb_we = 1; wb_addr = 9; wb_data = $urandom;
    step();
  endtask

  task automatic test_x0();
    clean();
    drive_instr(0, 0, 0, 0, 1, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL x0_rd got=%b exp=1", in_ready); end
    step();
    drive_instr(1, 0, 0, 12, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL x0_rs1 got=%b exp=1", in_ready); end
    checks++; if (re1 !== 1'b1 || re2 !== 1'b0 || raddr2 !== 5'd12) begin failures++; $display("FAIL x0_re got=%b%b,%0d exp=10,12", re1, re2, raddr2); end
    step();
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'd0 || out_op2 !== 32'd0) begin failures++; $display("FAIL x0_ops got=%b,%h,%h exp=1,0,0", out_valid, out_op1, out_op2); end
    drive_idle();
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] base, held;
    clean();
    base = stall_cnt;
    out_ready = 0;
    drive_instr(0, 0, 0, 0, 1, 10);
    step();
    held = m_payload;
    drive_instr(1, 1, 1, 2, 1, 11);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd10 || out_payload !== held) begin failures++; $display("FAIL bp_hold%0d got=%b,%0d,%h exp=1,10,%h", i, out_valid, out_rd, out_payload, held); end
    end
    checks++; if (stall_cnt !== base) begin failures++; $display("FAIL bp_cnt got=%h exp=%h", stall_cnt, base); end
    drive_idle();
    rdy = 0; wb_we = 1; wb_addr = 10; wb_data = $urandom;
    step();
    drive_idle();
    drive_instr(1, 10, 0, 0, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rdy0_wb_ignored got=%b exp=0", in_ready); end
    step();
    drive_instr(0, 0, 0, 0, 1, 3);
    step();
    drive_instr(0, 0, 0, 0, 1, 6);
    step();
    drive_idle();
    out_ready = 0; flush = 1;
    step();
    flush = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    drive_instr(1, 3, 1, 6, 1, 10);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", in_ready); end
    step();
    drive_idle();
    step();
  endtask

  task automatic test_random();
    bit exp_rdy;
    int q[$];
    clean();
    for (int n = 0; n < 800; n++) begin
      rdy        = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_use_rs1 = $urandom_range(0, 1);
      in_use_rs2 = $urandom_range(0, 1);
      in_rd_we   = $urandom_range(0, 1);
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_payload = $urandom;
      wb_we      = ($urandom_range(0, 2) == 0);
      wb_data    = $urandom;
      q = {};
      foreach (m_busy[i]) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0) wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
      else              wb_addr = 5'($urandom_range(0, 7));
      #1;
      exp_rdy = m_in_ready();
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_rdy); end
      checks++; if (re1 !== (in_valid & in_use_rs1) || re2 !== (in_valid & in_use_rs2) || raddr1 !== in_rs1) begin failures++; $display("FAIL rnd_read n=%0d got=%b%b,%0d exp=%b%b,%0d", n, re1, re2, raddr1, in_valid & in_use_rs1, in_valid & in_use_rs2, in_rs1); end
      step();
      checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, m_valid); end
      checks++; if (stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt n=%0d got=%h exp=%h", n, stall_cnt, m_cnt); end
      if (m_valid) begin
        checks++;
        if (out_op1 !== m_op1 || out_op2 !== m_op2 || out_rd !== m_rd || out_rd_we !== m_rd_we || out_payload !== m_payload) begin
          failures++;
          $display("FAIL rnd_data n=%0d got=%h,%h,%0d,%b,%h exp=%h,%h,%0d,%b,%h", n, out_op1, out_op2, out_rd, out_rd_we, out_payload, m_op1, m_op2, m_rd, m_rd_we, m_payload);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    model_reset();
    test_reset();
    test_independent();
    test_raw();
    test_collision();
    test_x0();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Reader side of the 32-entry integer register file; sits between decode and execute.
- Accepts one decoded instruction per cycle and drives the register file's two read ports.
- Tracks in-flight destination registers in a busy scoreboard and stalls on RAW/WAW hazards.
- Delivers operands through a one-entry valid/ready output register and observes the writeback bus to clear busy bits.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 reads as zero and is never busy.
- REG_AW, 5, register address width (log2 REG_NUM).
- XLEN, 32, data width.
- PW, 32, width of the opaque payload (pc/opcode bundle) passed through unchanged.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes all state
- flush  in  1  squash held output and clear scoreboard
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle
- in_use_rs1 / in_use_rs2  in  1 each  source operand used
- in_rs1 / in_rs2  in  REG_AW each  source addresses
- in_rd_we  in  1  instruction writes rd
- in_rd  in  REG_AW  destination address
- in_payload  in  PW  passthrough
- re1 / re2  out  1 each  register-file read enables
- raddr1 / raddr2  out  REG_AW each  register-file read addresses
- rdata1 / rdata2  in  XLEN each  register-file read data, combinational, with same-cycle write bypass
- wb_we  in  1  writeback strobe, the same signal as the register-file write enable
- wb_addr  in  REG_AW  writeback address
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_op1 / out_op2  out  XLEN each  operands; zero when the source is unused
- out_rd_we / out_rd / out_payload  out  1 / REG_AW / PW  forwarded fields
- stall_cnt  out  32  hazard-stall cycle counter, saturating

Behaviour:
- Reset (rst=0, async): out_valid=0, busy=0, stall_cnt=0, and out_op1, out_op2, out_rd, out_rd_we, out_payload=0.
- Read ports are combinational from the inputs: re1=in_valid&in_use_rs1, raddr1=in_rs1. re2/raddr2 follow the same rule.
- Effective busy: eb[r] = busy[r] & ~(wb_we & wb_addr==r & rdy). eb[0] is always 0.
- hazard = in_valid & ((in_use_rs1 & eb[rs1]) | (in_use_rs2 & eb[rs2]) | (in_rd_we & eb[rd])).
- slot_free = ~out_valid | out_ready.
- in_ready = rdy & ~flush & slot_free & ~hazard.
- issue = in_valid & in_ready.
- Output register has two states, EMPTY and FULL.
  - EMPTY -> FULL on issue.
  - FULL -> EMPTY on out_ready with no issue.
  - FULL -> FULL on out_ready with issue (back-to-back, zero bubble).
  - FULL holds all fields while out_ready=0.
- Issue latency: 1 cycle, in_valid to out_valid.
  - Operands are captured from rdata at the issue edge.
  - A same-cycle writeback to a source is picked up through the register-file bypass.
- Scoreboard, per clock edge:
  - busy[wb_addr] is cleared on wb_we.
  - busy[in_rd] is set on issue when in_rd_we and in_rd!=0.
  - If set and clear hit the same register, set wins.
- rdy=0: no issue, no output change, scoreboard unchanged (writebacks are ignored, matching the register file), stall_cnt unchanged.
- flush=1 with rdy=1: next cycle out_valid=0 and busy all 0; no issue that cycle. Flush has priority over out_ready and over wb clears.
- stall_cnt increments on cycles with rdy & in_valid & ~flush & hazard; it saturates at 0xFFFFFFFF.
- Output-full back-pressure (no hazard) is not counted.

Decomposition:
- Shared package holds: REG_NUM, REG_AW, XLEN, ZeroWord, WriteEnable/ReadEnable levels, and the EMPTY/FULL state encoding.
- One sub-module, reg_scoreboard, contains busy[], the set/clear logic, eb[] and the three hazard compares.
- The top level contains the handshake, output register and counter.

Test Plan:
- Reset mid-operation: out_valid=1 and busy[5]=1, then rst=0 asynchronously -> out_valid=0, busy=0, stall_cnt=0 immediately, with no clock edge needed.
- Independent stream: rs1=1/rs2=2/rd=3, then rs1=4/rs2=5/rd=6, out_ready=1 -> both issue back-to-back, out_op1/out_op2 equal regs[1]/regs[2] then regs[4]/regs[5], stall_cnt=0.
- RAW stall: issue rd=7, then rs1=7 -> in_ready=0 for 3 cycles, stall_cnt=3. wb_we=1, wb_addr=7, data 0xDEADBEEF -> issues that same cycle, out_op1=0xDEADBEEF next cycle.
- Set/clear collision: busy[9]=1, wb_addr=9 and issue rd=9 in the same cycle -> busy[9]=1 afterwards. A following rs1=9 stalls.
- rd=x0 and unused sources: rd=0 with in_rd_we=1, then rs1=0 -> no stall. in_use_rs2=0 -> re2=0, out_op2=0.
- Back-pressure, rdy and flush:
  - out_ready=0 -> output held, in_ready=0, stall_cnt not incremented.
  - rdy=0 while wb_we=1 -> busy bit not cleared.
  - flush with out_valid=1 and busy[3,6]=1 -> out_valid=0 and busy=0 next cycle.
